regfile_writeback: RTL and testbench

Write-side controller for the 32-entry register file. It merges single-cycle ALU results with in-order data-memory load responses and drives the register file write port (`ad3`, `we3`, `wd3`). It also keeps a per-register busy scoreboard so decode can stall reads and issues that depend on an outstanding load. It sits between execute/memory and the register file; the register file's read ports are untouched.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/regfile_writeback.sv | 149 ++++++++++++++
 tb/tb_regfile_writeback.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file write-back path.
package regfile_pkg;
    localparam int RF_ADDRESS_WIDTH = 5;
    localparam int RF_DATA_WIDTH    = 32;

    typedef logic [RF_ADDRESS_WIDTH-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t                 rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed once counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Register file write-port controller: merges ALU results with in-order load
// responses and tracks which registers still await a load.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int LQ_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ld_issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]      ld_issue_rd,
    output logic                          ld_issue_ready,
    input  logic                          ld_resp_valid,
    input  logic [DATA_WIDTH-1:0]         ld_resp_data,
    output logic                          ld_resp_ready,
    output logic [ADDRESS_WIDTH-1:0]      ad3,
    output logic                          we3,
    output logic [DATA_WIDTH-1:0]         wd3,
    output logic [(1<<ADDRESS_WIDTH)-1:0] busy,
    output logic                          err
);
    localparam int NREGS    = 1 << ADDRESS_WIDTH;
    localparam int WB_WIDTH = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int WB_DEPTH = 2;

    logic                     tag_push;
    logic                     tag_pop;
    logic                     tag_full;
    logic                     tag_empty;
    logic [ADDRESS_WIDTH-1:0] tag_head;

    logic                     wb_push;
    logic                     wb_pop;
    logic                     wb_full;
    logic                     wb_empty;
    logic [WB_WIDTH-1:0]      wb_in;
    logic [WB_WIDTH-1:0]      wb_head;
    logic [ADDRESS_WIDTH-1:0] wb_head_rd;
    logic [DATA_WIDTH-1:0]    wb_head_data;

    logic                     issue_acc;
    logic                     resp_acc;
    logic                     alu_win;

    logic [NREGS-1:0]         busy_reg;
    logic [NREGS-1:0]         busy_next;
    logic [ADDRESS_WIDTH-1:0] ad3_reg;
    logic [DATA_WIDTH-1:0]    wd3_reg;
    logic                     we3_reg;
    logic                     from_load_reg;
    logic                     err_reg;

    assign ld_issue_ready = !tag_full && !busy_reg[ld_issue_rd];
    assign ld_resp_ready  = !wb_full;
    assign issue_acc      = ld_issue_valid && ld_issue_ready;
    assign resp_acc       = ld_resp_valid && ld_resp_ready;

    assign tag_push = issue_acc;
    assign tag_pop  = resp_acc && !tag_empty;
    assign wb_push  = resp_acc && !tag_empty;
    assign wb_in    = {tag_head, ld_resp_data};

    assign wb_head_rd   = wb_head[WB_WIDTH-1:DATA_WIDTH];
    assign wb_head_data = wb_head[DATA_WIDTH-1:0];
    assign alu_win      = alu_valid && (alu_rd != '0);
    assign wb_pop       = !alu_win && !wb_empty;

    sync_fifo #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (LQ_DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (ld_issue_rd),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    sync_fifo #(
        .WIDTH (WB_WIDTH),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_data (wb_in),
        .pop       (wb_pop),
        .pop_data  (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    // A busy bit drops on the edge that commits its load write; x0 is never busy.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] =
                    (busy_reg[gi] && !(we3_reg && from_load_reg && ad3_reg == ADDRESS_WIDTH'(gi)))
                    || (issue_acc && ld_issue_rd == ADDRESS_WIDTH'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ad3_reg       <= '0;
            wd3_reg       <= '0;
            we3_reg       <= 1'b0;
            from_load_reg <= 1'b0;
            busy_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            if (resp_acc && tag_empty) begin
                err_reg <= 1'b1;
            end
            if (alu_win) begin
                ad3_reg       <= alu_rd;
                wd3_reg       <= alu_data;
                we3_reg       <= 1'b1;
                from_load_reg <= 1'b0;
            end else if (!wb_empty) begin
                ad3_reg       <= wb_head_rd;
                wd3_reg       <= wb_head_data;
                we3_reg       <= (wb_head_rd != '0);
                from_load_reg <= 1'b1;
            end else begin
                we3_reg       <= 1'b0;
                from_load_reg <= 1'b0;
            end
        end
    end

    assign ad3  = ad3_reg;
    assign wd3  = wd3_reg;
    assign we3  = we3_reg;
    assign busy = busy_reg;
    assign err  = err_reg;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: queue-based reference model predicts
// each register-file write and the per-cycle ready/busy/err outputs.
module tb_regfile_writeback;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  ad3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic        err;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_ready  (ld_resp_ready),
        .ad3            (ad3),
        .we3            (we3),
        .wd3            (wd3),
        .busy           (busy),
        .err            (err)
    );

    typedef struct {
        int          cyc;
        reg_idx_t    rd;
        logic [31:0] data;
    } exp_t;

    int        tests = 0;
    int        fails = 0;
    int        cyc   = 0;
    exp_t      exp_q[$];
    exp_t      mon_e;
    reg_idx_t  m_tags[$];
    wb_entry_t m_wb[$];
    logic [31:0] m_busy = '0;
    bit        m_err = 1'b0;
    int        m_clear = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write seen on the port must be the next predicted one, on its cycle.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write cyc=%0d got ad3=%0d wd3=%h required no write", cyc, ad3, wd3);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || ad3 !== mon_e.rd || wd3 !== mon_e.data) begin
                    fails++;
                    $display("FAIL write cyc=%0d got ad3=%0d wd3=%h required cyc=%0d ad3=%0d wd3=%h",
                             cyc, ad3, wd3, mon_e.cyc, mon_e.rd, mon_e.data);
                end else begin
                    $display("[TB] cyc=%0d write x%0d=%h", cyc, ad3, wd3);
                end
            end
        end
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
        end
    endtask

    // Compare the combinational outputs against the model, advance the model by one edge.
    task automatic step();
        bit        er, rr, iacc, racc;
        int        nc;
        wb_entry_t w;
        exp_t      e;
        #1;
        er = (m_tags.size() < 4) && !m_busy[ld_issue_rd];
        rr = (m_wb.size() < 2);
        check("ld_issue_ready", 64'(ld_issue_ready), 64'(er));
        check("ld_resp_ready", 64'(ld_resp_ready), 64'(rr));
        check("busy", 64'(busy), 64'(m_busy));
        check("err", 64'(err), 64'(m_err));
        if (rst) begin
            m_tags.delete();
            m_wb.delete();
            m_busy  = '0;
            m_err   = 1'b0;
            m_clear = -1;
        end else begin
            iacc = ld_issue_valid && er;
            racc = ld_resp_valid && rr;
            nc   = -1;
            if (alu_valid && alu_rd != 0) begin
                e.cyc = cyc + 1; e.rd = alu_rd; e.data = alu_data;
                exp_q.push_back(e);
            end else if (m_wb.size() > 0) begin
                w = m_wb.pop_front();
                if (w.rd != 0) begin
                    e.cyc = cyc + 1; e.rd = w.rd; e.data = w.data;
                    exp_q.push_back(e);
                    nc = int'(w.rd);
                end
            end
            if (racc) begin
                if (m_tags.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    w.rd   = m_tags.pop_front();
                    w.data = ld_resp_data;
                    m_wb.push_back(w);
                end
            end
            if (m_clear >= 0) m_busy[m_clear] = 1'b0;
            if (iacc) begin
                m_tags.push_back(ld_issue_rd);
                if (ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
            end
            m_clear = nc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit av, int ard, logic [31:0] ad, bit iv, int ird, bit rv, logic [31:0] rdat);
        alu_valid      = av;
        alu_rd         = 5'(ard);
        alu_data       = ad;
        ld_issue_valid = iv;
        ld_issue_rd    = 5'(ird);
        ld_resp_valid  = rv;
        ld_resp_data   = rdat;
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue_valid = 0; ld_issue_rd = 0; ld_resp_valid = 0; ld_resp_data = 0;
        @(posedge clk);
        #1;
        idle(2);
        check("reset_we3", 64'(we3), 64'd0);
        check("reset_ad3", 64'(ad3), 64'd0);
        check("reset_wd3", 64'(wd3), 64'd0);
        rst = 1'b0;

        // ALU writes, including a dropped write to x0
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 0, 32'h11111111, 0, 0, 0, 0);
        idle(2);

        // Single load to x7, response two cycles later
        drive(0, 0, 0, 1, 7, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 1, 32'h1234);
        idle(3);

        // Responses collide with three ALU writes to x3
        drive(0, 0, 0, 1, 9, 0, 0);
        drive(0, 0, 0, 1, 10, 0, 0);
        drive(0, 0, 0, 1, 11, 0, 0);
        drive(1, 3, 32'hA0, 0, 0, 1, 32'h900);
        drive(1, 3, 32'hA1, 0, 0, 1, 32'hA00);
        drive(1, 3, 32'hA2, 0, 0, 1, 32'hB00);
        drive(0, 0, 0, 0, 0, 1, 32'hB00);
        drive(0, 0, 0, 0, 0, 1, 32'hB00);
        idle(4);

        // Fill the tag queue, then try a 5th issue and a busy-register issue
        for (int r = 1; r <= 4; r++) drive(0, 0, 0, 1, r, 0, 0);
        drive(0, 0, 0, 1, 6, 0, 0);
        drive(0, 0, 0, 1, 2, 1, 32'h100);
        for (int r = 2; r <= 4; r++) drive(0, 0, 0, 0, 0, 1, 32'h100 * r);
        idle(4);

        // Load to x0, then a response with no tag outstanding
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h5555);
        idle(2);
        drive(0, 0, 0, 0, 0, 1, 32'h6666);
        idle(3);

        // Reset with loads outstanding and one buffered, then a late response
        rst = 1'b1; idle(1); rst = 1'b0;
        drive(0, 0, 0, 1, 12, 0, 0);
        drive(0, 0, 0, 1, 13, 0, 0);
        drive(0, 0, 0, 1, 14, 0, 0);
        drive(1, 8, 32'hCAFE, 0, 0, 1, 32'hC00);
        rst = 1'b1;
        drive(1, 8, 32'hCAFF, 0, 0, 0, 0);
        rst = 1'b0;
        check("post_reset_we3", 64'(we3), 64'd0);
        drive(0, 0, 0, 0, 0, 1, 32'hD00);
        idle(3);

        // Randomized traffic
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit rv;
            rv  = (m_tags.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7), rv, $urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, m_tags.size() > 0, $urandom);
        idle(4);

        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
